// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback requester, hazard-tap and reg_file write-port bundle
interface rf_wb_arbiter_if #(parameter int ADDR_W = 6, DATA_W = 64, DEPTH = 2);
  localparam int NW = $clog2(2 * DEPTH + 1) + 1;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [ADDR_W-1:0] addr_r1;
  logic [ADDR_W-1:0] addr_r2;
  logic              hz_r1;
  logic              hz_r2;
  logic              wr_en;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic [NW-1:0]     pending;
  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, addr_r1, addr_r2,
    input  req0_ready, req1_ready, hz_r1, hz_r2, wr_en, in_addr, in_data, pending
  );
  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, addr_r1, addr_r2,
    output req0_ready, req1_ready, hz_r1, hz_r2, wr_en, in_addr, in_data, pending
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two buffered writeback requesters round-robin onto one reg_file write port with RAW hazard flags
module rf_wb_arbiter #(parameter int ADDR_W = 6, DATA_W = 64, DEPTH = 2) (
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(2 * DEPTH + 1) + 1;
  logic [ADDR_W-1:0] r_addr [2][DEPTH];
  logic [DATA_W-1:0] r_data [2][DEPTH];
  logic [PW-1:0]     r_wp [2];
  logic [PW-1:0]     r_rp [2];
  logic [CW-1:0]     r_cnt [2];
  logic              r_last;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_in_addr;
  logic [DATA_W-1:0] r_in_data;
  logic [NW-1:0]     r_pending;
  logic [1:0]        w_valid, w_ready, w_push, w_ne, w_gnt;
  logic [ADDR_W-1:0] w_addr [2];
  logic [DATA_W-1:0] w_data [2];
  logic [CW-1:0]     w_cnt_nxt [2];
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_hz1, w_hz2, w_slot;
  assign w_valid = {bus.req1_valid, bus.req0_valid};
  assign w_addr[0] = bus.req0_addr;
  assign w_addr[1] = bus.req1_addr;
  assign w_data[0] = bus.req0_data;
  assign w_data[1] = bus.req1_data;
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_ready[n]   = r_cnt[n] < CW'(DEPTH);
      w_push[n]    = w_valid[n] && w_ready[n];
      w_ne[n]      = r_cnt[n] != '0;
    end
    // r_last holds the most recent winner; on a tie the other side goes next
    w_gnt[0] = w_ne[0] && (!w_ne[1] || r_last);
    w_gnt[1] = w_ne[1] && (!w_ne[0] || !r_last);
    for (int n = 0; n < 2; n++)
      w_cnt_nxt[n] = r_cnt[n] + CW'(w_push[n]) - CW'(w_gnt[n]);
    w_head_addr = w_gnt[1] ? r_addr[1][r_rp[1]] : r_addr[0][r_rp[0]];
    w_head_data = w_gnt[1] ? r_data[1][r_rp[1]] : r_data[0][r_rp[0]];
  end
  always_comb begin
    w_hz1  = r_wr_en && r_in_addr == bus.addr_r1;
    w_hz2  = r_wr_en && r_in_addr == bus.addr_r2;
    w_slot = 1'b0;
    // a slot is live when its distance from the read pointer is below the count
    for (int n = 0; n < 2; n++)
      for (int j = 0; j < DEPTH; j++) begin
        w_slot = CW'(PW'(PW'(j) - r_rp[n])) < r_cnt[n];
        w_hz1  = w_hz1 | (w_slot && r_addr[n][j] == bus.addr_r1);
        w_hz2  = w_hz2 | (w_slot && r_addr[n][j] == bus.addr_r2);
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        r_wp[n]  <= '0;
        r_rp[n]  <= '0;
        r_cnt[n] <= '0;
      end
      r_last    <= 1'b1;
      r_wr_en   <= 1'b0;
      r_in_addr <= '0;
      r_in_data <= '0;
      r_pending <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_push[n]) begin
          r_addr[n][r_wp[n]] <= w_addr[n];
          r_data[n][r_wp[n]] <= w_data[n];
          r_wp[n]            <= r_wp[n] + 1'b1;
        end
        if (w_gnt[n]) r_rp[n] <= r_rp[n] + 1'b1;
        r_cnt[n] <= w_cnt_nxt[n];
      end
      if (|w_gnt) begin
        r_last    <= w_gnt[1];
        r_in_addr <= w_head_addr;
        r_in_data <= w_head_data;
      end
      r_wr_en   <= |w_gnt;
      r_pending <= NW'(w_cnt_nxt[0]) + NW'(w_cnt_nxt[1]) + NW'(|w_gnt);
    end
  end
  assign bus.req0_ready = w_ready[0];
  assign bus.req1_ready = w_ready[1];
  assign bus.hz_r1      = w_hz1;
  assign bus.hz_r2      = w_hz2;
  assign bus.wr_en      = r_wr_en;
  assign bus.in_addr    = r_in_addr;
  assign bus.in_data    = r_in_data;
  assign bus.pending    = r_pending;
endmodule
